// File: rtl/ps2_kbd_seq.sv
// PS/2 set-2 sequencer: folds E0/F0/E1 prefixes into key events and drops status bytes into batOk/kbErr pulses.
// Events are written on the byte edge and show on valid one clock later; a write into a full FIFO is dropped and sets overflow.
module ps2_kbd_seq #(
  parameter int DEPTH = 8,
  parameter int TMO   = 4096
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ce,
  input  logic                     strb,
  input  logic [7:0]               code,
  input  logic                     rd,
  output logic                     valid,
  output logic [7:0]               key,
  output logic                     extended,
  output logic                     released,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clrOvf,
  output logic                     batOk,
  output logic                     kbErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
  localparam logic [LW-1:0] CNT_FULL = LW'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_EXT    = 3'd1;
  localparam logic [2:0] S_BRK    = 3'd2;
  localparam logic [2:0] S_EXTBRK = 3'd3;
  localparam logic [2:0] S_PAUSE  = 3'd4;

  logic [2:0]    r_state, w_state_nxt;
  logic [2:0]    r_pcnt, w_pcnt_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic          w_byte;
  logic          w_emit, w_ev_rel, w_ev_ext;
  logic [7:0]    w_ev_code;
  logic          w_bat, w_err;
  logic          r_bat, r_err;

  assign w_byte = ce & strb;

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_tmo_nxt   = r_tmo;
    w_emit      = 1'b0;
    w_ev_rel    = 1'b0;
    w_ev_ext    = 1'b0;
    w_ev_code   = code;
    w_bat       = 1'b0;
    w_err       = 1'b0;
    if (w_byte) begin
      w_tmo_nxt = '0;
      case (r_state)
        S_IDLE: begin
          case (code)
            8'hE0: w_state_nxt = S_EXT;
            8'hF0: w_state_nxt = S_BRK;
            8'hE1: begin
              w_state_nxt = S_PAUSE;
              w_pcnt_nxt  = 3'd7;
            end
            8'hAA: w_bat = 1'b1;
            8'h00, 8'hFF, 8'hFC: w_err = 1'b1;
            8'hFA, 8'hFE, 8'hEE: ;
            default: w_emit = 1'b1;
          endcase
        end
        S_EXT: begin
          if (code == 8'hF0) begin
            w_state_nxt = S_EXTBRK;
          end else if (code != 8'hE0) begin
            w_emit      = 1'b1;
            w_ev_ext    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          if (code == 8'hE0) begin
            w_state_nxt = S_EXTBRK;
          end else if (code != 8'hF0) begin
            w_emit      = 1'b1;
            w_ev_rel    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_EXTBRK: begin
          if (code != 8'hE0 && code != 8'hF0) begin
            w_emit      = 1'b1;
            w_ev_rel    = 1'b1;
            w_ev_ext    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_PAUSE: begin
          // The Pause make sequence is 8 bytes long regardless of content
          w_pcnt_nxt = r_pcnt - 3'd1;
          if (r_pcnt == 3'd1) begin
            w_emit      = 1'b1;
            w_ev_ext    = 1'b1;
            w_ev_code   = 8'h77;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (ce) begin
      if (r_state == S_IDLE) begin
        w_tmo_nxt = '0;
      end else if (r_tmo == TMO_LAST) begin
        w_state_nxt = S_IDLE;
        w_tmo_nxt   = '0;
      end else begin
        w_tmo_nxt = r_tmo + TW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pcnt  <= 3'd0;
      r_tmo   <= '0;
      r_bat   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_tmo   <= w_tmo_nxt;
      r_bat   <= w_bat;
      r_err   <= w_err;
    end
  end

  assign batOk = r_bat;
  assign kbErr = r_err;

  // Event FIFO, entries packed as {rel, ext, code}
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_cnt;
  logic [9:0]    r_hold;
  logic [9:0]    w_head;
  logic          w_full, w_pop, w_wr, w_ovf_set;
  logic          r_ovf;

  assign valid     = (r_cnt != '0);
  assign w_full    = (r_cnt == CNT_FULL);
  assign w_pop     = rd & valid;
  assign w_wr      = w_emit & (~w_full | w_pop);
  assign w_ovf_set = w_emit & w_full & ~w_pop;

  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wptr] <= {w_ev_rel, w_ev_ext, w_ev_code};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_hold <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_hold <= r_mem[r_rptr];
      end
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + LW'(1);
        2'b01:   r_cnt <= r_cnt - LW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (clrOvf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // An empty FIFO keeps showing the last popped event
  assign w_head   = valid ? r_mem[r_rptr] : r_hold;
  assign key      = w_head[7:0];
  assign extended = w_head[8];
  assign released = w_head[9];
  assign level    = r_cnt;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_ps2_kbd_seq.sv
// Directed bench for ps2_kbd_seq: byte-sequence table plus hand sequences for timeout, overflow and reset.
module tb_ps2_kbd_seq;

  localparam int TB_DEPTH = 8;
  localparam int TB_TMO   = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic       strb = 1'b0;
  logic [7:0] code = 8'h00;
  logic       rd = 1'b0;
  logic       clrOvf = 1'b0;
  logic       valid;
  logic [7:0] key;
  logic       extended;
  logic       released;
  logic [$clog2(TB_DEPTH):0] level;
  logic       overflow;
  logic       batOk;
  logic       kbErr;

  ps2_kbd_seq #(.DEPTH(TB_DEPTH), .TMO(TB_TMO)) dut (
    .clock(clock), .reset(reset), .ce(ce), .strb(strb), .code(code), .rd(rd),
    .valid(valid), .key(key), .extended(extended), .released(released),
    .level(level), .overflow(overflow), .clrOvf(clrOvf), .batOk(batOk), .kbErr(kbErr)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [79:0] bytes;
    logic [3:0]  nb;
    logic [1:0]  nev;
    logic [19:0] evs;
    logic [1:0]  nbat;
    logic [1:0]  nerr;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int bat_seen = 0;
  int err_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tk();
    @(posedge clock);
    #1;
    if (batOk) bat_seen++;
    if (kbErr) err_seen++;
  endtask

  task automatic send(input logic [7:0] b);
    ce = 1'b1;
    strb = 1'b1;
    code = b;
    tk();
    ce = 1'b0;
    strb = 1'b0;
  endtask

  task automatic pop_chk(input string nm, input logic [9:0] ev);
    chk({nm, "_valid"}, {31'd0, valid}, 32'd1);
    chk({nm, "_event"}, {22'd0, released, extended, key}, {22'd0, ev});
    rd = 1'b1;
    tk();
    rd = 1'b0;
  endtask

  function automatic vec_t mk(input logic [79:0] b, input int nb, input int nev,
                              input logic [9:0] e0, input logic [9:0] e1,
                              input int nbat, input int nerr);
    vec_t v;
    v.bytes = b;
    v.nb    = 4'(nb);
    v.nev   = 2'(nev);
    v.evs   = {e0, e1};
    v.nbat  = 2'(nbat);
    v.nerr  = 2'(nerr);
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    // Events written as {rel, ext, code}
    vecs[0] = mk({8'h1C, 8'hF0, 8'h1C, 56'h0}, 3, 2, 10'h01C, 10'h21C, 0, 0);
    vecs[1] = mk({8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 40'h0}, 5, 2, 10'h175, 10'h375, 0, 0);
    vecs[2] = mk({8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C, 8'h0},
                 9, 2, 10'h177, 10'h01C, 0, 0);
    vecs[3] = mk({8'hAA, 8'hFA, 8'hFC, 56'h0}, 3, 0, 10'h0, 10'h0, 1, 1);
    vecs[4] = mk({8'hF0, 8'hE0, 8'h11, 56'h0}, 3, 1, 10'h311, 10'h0, 0, 0);
    vecs[5] = mk({8'hE0, 8'hAA, 8'hF0, 8'hFA, 48'h0}, 4, 2, 10'h1AA, 10'h2FA, 0, 0);
    vecs[6] = mk({8'h00, 8'hFF, 8'hEE, 8'hFE, 48'h0}, 4, 0, 10'h0, 10'h0, 0, 2);
    vecs[7] = mk({8'hF0, 8'hF0, 8'h5A, 8'hE0, 8'hE0, 8'h4A, 32'h0}, 6, 2, 10'h25A, 10'h14A, 0, 0);

    #23;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_level", {28'd0, level}, 32'd0);
    chk("rst_head", {22'd0, released, extended, key}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_pulses", {30'd0, batOk, kbErr}, 32'd0);
    reset = 1'b0;
    tk();

    for (int r = 0; r < 8; r++) begin
      bat_seen = 0;
      err_seen = 0;
      for (int i = 0; i < int'(vecs[r].nb); i++) begin
        send(vecs[r].bytes[79 - 8*i -: 8]);
        if (r == 0 && i == 0) chk("v0_first_valid", {31'd0, valid}, 32'd1);
      end
      tk();
      chk($sformatf("v%0d_level", r), {28'd0, level}, {30'd0, vecs[r].nev});
      chk($sformatf("v%0d_bat", r), bat_seen, {30'd0, vecs[r].nbat});
      chk($sformatf("v%0d_err", r), err_seen, {30'd0, vecs[r].nerr});
      for (int j = 0; j < int'(vecs[r].nev); j++) begin
        pop_chk($sformatf("v%0d_ev%0d", r, j), (j == 0) ? vecs[r].evs[19:10] : vecs[r].evs[9:0]);
      end
      chk($sformatf("v%0d_empty", r), {31'd0, valid}, 32'd0);
    end

    // Timeout: full TMO idle ticks abort the E0 prefix
    send(8'hE0);
    ce = 1'b1;
    repeat (TB_TMO) tk();
    ce = 1'b0;
    chk("tmo_noemit", {28'd0, level}, 32'd0);
    send(8'h1C);
    pop_chk("tmo_abort", 10'h01C);

    // Byte on the expiry tick wins over the abort
    send(8'hE0);
    ce = 1'b1;
    repeat (TB_TMO - 1) tk();
    ce = 1'b0;
    send(8'h1C);
    pop_chk("tmo_edge", 10'h11C);

    // ce=0 freezes the timeout counter
    send(8'hE0);
    repeat (3 * TB_TMO) tk();
    send(8'h1C);
    pop_chk("ce_freeze", 10'h11C);

    // Overflow and full-FIFO corner cases
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
    chk("ovf_level", {28'd0, level}, 32'd8);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_head", {24'd0, key}, 32'h10);
    clrOvf = 1'b1;
    tk();
    clrOvf = 1'b0;
    chk("ovf_clr", {31'd0, overflow}, 32'd0);
    rd = 1'b1;
    send(8'h20);
    rd = 1'b0;
    chk("full_wrrd_ovf", {31'd0, overflow}, 32'd0);
    chk("full_wrrd_level", {28'd0, level}, 32'd8);
    chk("full_wrrd_head", {24'd0, key}, 32'h11);
    clrOvf = 1'b1;
    send(8'h21);
    clrOvf = 1'b0;
    chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
    chk("ovf_drop_level", {28'd0, level}, 32'd8);
    clrOvf = 1'b1;
    tk();
    clrOvf = 1'b0;
    chk("ovf_clr2", {31'd0, overflow}, 32'd0);
    for (int k = 0; k < 7; k++) pop_chk($sformatf("drain%0d", k), 10'h011 + 10'(k));
    pop_chk("drain7", 10'h020);
    chk("drain_empty", {31'd0, valid}, 32'd0);
    chk("drain_level", {28'd0, level}, 32'd0);
    chk("hold_key", {24'd0, key}, 32'h20);

    // Write with rd while empty: rd ignored, write lands
    rd = 1'b1;
    send(8'h33);
    rd = 1'b0;
    chk("empty_wrrd_valid", {31'd0, valid}, 32'd1);
    chk("empty_wrrd_level", {28'd0, level}, 32'd1);
    pop_chk("empty_wrrd", 10'h033);

    // Reset in the middle of a Pause sequence
    send(8'h1C);
    send(8'hE1);
    send(8'h14);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_level", {28'd0, level}, 32'd0);
    chk("mid_rst_head", {22'd0, released, extended, key}, 32'd0);
    chk("mid_rst_ovf_pulses", {29'd0, overflow, batOk, kbErr}, 32'd0);
    #5;
    reset = 1'b0;
    tk();
    send(8'h1C);
    chk("post_rst_level", {28'd0, level}, 32'd1);
    pop_chk("post_rst", 10'h01C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_seq.md
Name: ps2_kbd_seq

Overview:
- Sequencer that sits directly behind the PS/2 byte receiver.
- Consumes its strb/code byte stream and resolves scan-code set 2 prefix sequences (E0, F0, E0 F0, E1 pause) into single key events.
- Filters keyboard status bytes and buffers events in a small FWFT FIFO, so the keyboard-matrix logic can read at its own pace.
- The decoder advances only on the receiver's ce/strb. The FIFO read side runs every clock.

Parameters:
DEPTH, 8, event FIFO entries; power of two, 2..64.
TMO, 4096, ce ticks a prefix state may wait for its next byte before aborting to IDLE.

Ports:
clock  input  1  system clock.
reset  input  1  asynchronous active-high reset.
ce  input  1  clock enable shared with the PS/2 receiver; the decoder acts only when ce=1.
strb  input  1  receiver byte strobe; qualified by ce.
code  input  8  receiver byte; valid when ce&&strb.
rd  input  1  pop FIFO head; ignored when valid=0.
valid  output  1  FIFO non-empty; head fields below are valid.
key  output  8  head event scan code.
extended  output  1  head event had E0 prefix (or was Pause).
released  output  1  head event had F0 prefix.
level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
overflow  output  1  sticky: an event was dropped because the FIFO was full.
clrOvf  input  1  synchronous clear of overflow.
batOk  output  1  one-clock pulse when AA is received in IDLE.
kbErr  output  1  one-clock pulse when 00, FF or FC is received in IDLE.

Behaviour:
- Reset (async): state=IDLE; FIFO empty; valid=0; level=0; key=0; extended=0; released=0; overflow=0; batOk=0; kbErr=0; timeout counter=0; pause counter=0.
- "Byte" means a cycle with ce=1 and strb=1. All decoder transitions below occur only on a byte, except timeout.
- IDLE:
  - E0 -> EXT; F0 -> BRK; E1 -> PAUSE with pcnt=7.
  - AA -> pulse batOk, stay IDLE.
  - 00/FF/FC -> pulse kbErr, stay IDLE.
  - FA/FE/EE -> dropped silently, stay IDLE.
  - Any other byte -> emit {rel=0, ext=0, code}.
- EXT:
  - F0 -> EXTBRK.
  - E0 -> stay EXT (duplicate ignored).
  - Other -> emit {rel=0, ext=1, code}, go IDLE.
- BRK:
  - F0 -> stay BRK.
  - E0 -> EXTBRK (tolerated reordering).
  - Other -> emit {rel=1, ext=0, code}, go IDLE.
- EXTBRK:
  - E0/F0 -> stay.
  - Other -> emit {rel=1, ext=1, code}, go IDLE.
- PAUSE:
  - Every byte, whatever its value, decrements pcnt.
  - The byte that brings pcnt to 0 emits {rel=0, ext=1, code=77} and returns to IDLE.
  - No release event is ever generated for Pause.
- Status-byte filtering (AA, 00, FF, FC, FA, FE, EE) applies in IDLE only. In EXT/BRK/EXTBRK those bytes are treated as ordinary codes.
- Timeout:
  - In EXT/BRK/EXTBRK/PAUSE, the counter increments on each ce tick with no byte and clears on every byte and in IDLE.
  - When it reaches TMO-1, state goes to IDLE with no emit.
  - A byte in the same ce tick as expiry takes precedence: it is processed normally and the counter clears.
- Emit latency: the event is written into the FIFO at the clock edge of the byte cycle. valid/level reflect it one clock later.
- FIFO:
  - First-word fall-through: key/extended/released always present the oldest entry while valid=1; they hold their last value when empty.
  - Pop on rd&&valid; the next entry appears on the following clock.
  - Write when full: the event is dropped, overflow is set, and contents are unchanged.
  - Write and pop in the same clock when full: both take effect, no overflow, level unchanged.
  - Write and rd in the same clock when empty: the write lands, rd is ignored, valid=1 next clock.
  - level increments on write-only, decrements on pop-only, and is unchanged on both or neither.
  - Pointers wrap modulo DEPTH.
- overflow:
  - Cleared by clrOvf.
  - A set in the same clock as clrOvf wins, so overflow stays 1.
- batOk/kbErr pulse for exactly one clock, the clock after the byte cycle.
- ce=0: the decoder and timeout are frozen. FIFO reads still function.
- Reset asserted mid-sequence (e.g. in EXTBRK or PAUSE) returns everything to reset values; a partial prefix is discarded.

Test Plan:
- Bytes 1C; F0 1C -> two events {0,0,1C} then {rel=1,ext=0,1C}. valid rises 1 clock after the first byte; level=2 before reads.
- Bytes E0 75; E0 F0 75 -> {ext=1,rel=0,75} then {ext=1,rel=1,75}. No event is produced for the prefix bytes.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {ext=1,rel=0,77}, state IDLE; next byte 1C -> {0,0,1C}.
- Bytes AA, FA, FC in IDLE -> batOk pulse, no event, kbErr pulse; level stays 0.
- E0 then TMO ce ticks idle, then 1C -> {ext=0,rel=0,1C}. Variant with 1C arriving on the expiry tick -> {ext=1,1C}.
- DEPTH=8: push 9 events with rd=0 -> level=8, overflow=1, and head is the first event. With rd held high during a write while full -> no overflow, level stays 8. Then clrOvf -> overflow=0. Also assert reset during PAUSE -> all outputs return to reset values.
